// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one pipelined memory read port among three requesters:
//   icache miss fill (i), dcache demand miss (d) and data prefetcher (p).
//   Every issued read is recorded in an in-order tracking FIFO holding
//   {source mask, block address}. Memory responses pop the FIFO head and are
//   steered back, one cycle later, to every requester named in the mask.
//
//   Arbitration: d > i > p, with a starvation counter that lets i beat d
//   after STARVE_LIM consecutive losses. One FIFO slot is always kept back
//   for demand traffic. A prefetch whose block is already in flight, or is
//   being granted to i/d this cycle, is acknowledged and dropped without
//   a memory read.
//
//   Optional build macro MEM_ARB_MERGE_EN: a demand d request whose block
//   is already in flight as a prefetch is merged into that FIFO entry
//   instead of issuing a second read. The default build (macro undefined)
//   always issues d to memory.
//
// Parameters
//   MAX_OUT     in-flight read limit / FIFO depth (power of 2, >= 2)
//   STARVE_LIM  consecutive d-over-i wins before i is forced through
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt          icache request (held until granted)
//   d_req/d_addr/d_gnt          dcache demand request (held until granted)
//   p_req/p_addr/p_gnt          prefetch request (may be withdrawn)
//   mem_req/mem_addr/mem_ready  memory read issue, block aligned address
//   mem_rvalid/mem_rdata        in-order memory response
//   i_rvalid/d_rvalid/p_rvalid  registered response strobes
//   r_addr/r_data               registered response block address / data
//   err                         sticky: response arrived with nothing in flight
module mem_req_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_gnt,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  input  logic        p_req,
  input  logic [15:0] p_addr,
  output logic        p_gnt,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic        p_rvalid,
  output logic [15:0] r_addr,
  output logic [63:0] r_data,
  output logic        err
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  localparam logic [2:0] SRC_I = 3'b001;
  localparam logic [2:0] SRC_D = 3'b010;
  localparam logic [2:0] SRC_P = 3'b100;

  // Tracking FIFO. Entry validity is derived from rd_ptr/count, so the
  // storage itself needs no reset.
  logic [2:0]       ent_mask [MAX_OUT];
  logic [13:0]      ent_blk  [MAX_OUT];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [STV_W-1:0] starve_cnt;

  logic [MAX_OUT-1:0] ent_vld;
  logic [13:0]        i_blk;
  logic [13:0]        d_blk;
  logic [13:0]        p_blk;
  logic [2:0]         head_mask;
  logic [13:0]        head_blk;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic slot_dem;
  logic slot_pf;
  logic starved;
  logic can_issue;
  logic i_ok;
  logic d_ok;
  logic win_i;
  logic win_d;
  logic d_issue;
  logic d_merge;
  logic p_hit;
  logic p_dup;
  logic p_issue;
  logic push;
  logic [2:0]  push_mask;
  logic [13:0] dem_blk;
  logic [13:0] push_blk;

  // Word-offset bits never reach memory: reads are whole blocks.
  logic unused_word_bits;
  assign unused_word_bits = ^{i_addr[1:0], d_addr[1:0], p_addr[1:0]};

  assign i_blk     = i_addr[15:2];
  assign d_blk     = d_addr[15:2];
  assign p_blk     = p_addr[15:2];
  assign head_mask = ent_mask[rd_ptr];
  assign head_blk  = ent_blk[rd_ptr];

  // An entry is live when its distance from the head is below the count;
  // the subtraction wraps modulo MAX_OUT along with the pointers.
  always_comb begin
    ent_vld = '0;
    for (int k = 0; k < MAX_OUT; k++) begin
      ent_vld[k] = ({1'b0, PTR_W'(k) - rd_ptr} < count);
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(MAX_OUT));
  assign pop        = mem_rvalid && !fifo_empty;
  // A response leaving this cycle frees its slot for a demand issue at once.
  assign slot_dem   = !fifo_full || pop;
  // Prefetch never takes the last slot, so demand misses cannot be blocked
  // by speculative traffic.
  assign slot_pf    = (count < CNT_W'(MAX_OUT - 1));
  assign starved    = (starve_cnt == STV_W'(STARVE_LIM));
  assign can_issue  = mem_ready && slot_dem;

`ifdef MEM_ARB_MERGE_EN
  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx;

  // At most one live entry per block can carry the p bit (prefetches are
  // deduplicated against the FIFO), so the search needs no priority order.
  // The head entry is excluded when it is leaving this cycle.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int k = 0; k < MAX_OUT; k++) begin
      if (ent_vld[k] && ent_mask[k][2] && (ent_blk[k] == d_blk) &&
          !(pop && (PTR_W'(k) == rd_ptr))) begin
        merge_hit = 1'b1;
        merge_idx = PTR_W'(k);
      end
    end
  end

  assign d_merge = d_req && merge_hit;
`else
  assign d_merge = 1'b0;
`endif

  // Demand arbitration: d wins unless i has been starved for STARVE_LIM
  // cycles. A merge lets d win even without mem_ready or a free slot.
  assign i_ok    = i_req && can_issue;
  assign d_ok    = d_req && (d_merge || can_issue);
  assign win_i   = i_ok && (!d_ok || starved);
  assign win_d   = d_ok && !win_i;
  assign d_issue = win_d && !d_merge;
  assign dem_blk = win_i ? i_blk : d_blk;

  always_comb begin
    p_hit = 1'b0;
    for (int k = 0; k < MAX_OUT; k++) begin
      if (ent_vld[k] && (ent_blk[k] == p_blk)) begin
        p_hit = 1'b1;
      end
    end
  end

  // A duplicate prefetch is simply acknowledged: the data is already on
  // its way (or about to be) for another requester.
  assign p_dup   = p_req && (p_hit || ((win_i || win_d) && (dem_blk == p_blk)));
  assign p_issue = p_req && !p_dup && !win_i && !win_d && mem_ready && slot_pf;

  assign push      = win_i || d_issue || p_issue;
  assign push_mask = win_i ? SRC_I : (d_issue ? SRC_D : SRC_P);
  assign push_blk  = p_issue ? p_blk : dem_blk;

  // Combinational handshake outputs are forced low while reset is held.
  assign i_gnt    = rst_n && win_i;
  assign d_gnt    = rst_n && win_d;
  assign p_gnt    = rst_n && (p_dup || p_issue);
  assign mem_req  = rst_n && push;
  assign mem_addr = (rst_n && push) ? {push_blk, 2'b00} : 16'h0000;

  // ---- FIFO storage write (issue stage) ----
  always_ff @(posedge clk) begin
    if (push) begin
      ent_mask[wr_ptr] <= push_mask;
      ent_blk[wr_ptr]  <= push_blk;
    end
`ifdef MEM_ARB_MERGE_EN
    if (win_d && d_merge) begin
      ent_mask[merge_idx] <= ent_mask[merge_idx] | SRC_D;
    end
`endif
  end

  // ---- control state and registered response stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      p_rvalid   <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Counts consecutive cycles where i waits while d takes the port.
      if (!i_req || win_i) begin
        starve_cnt <= '0;
      end else if (win_d && !starved) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end

      i_rvalid <= pop && head_mask[0];
      d_rvalid <= pop && head_mask[1];
      p_rvalid <= pop && head_mask[2];
      if (pop) begin
        r_addr <= {head_blk, 2'b00};
        r_data <= mem_rdata;
      end

      if (mem_rvalid && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
`timescale 1ns/1ps
module tb_mem_req_arbiter;
  localparam int MAX_OUT    = 4;
  localparam int STARVE_LIM = 8;
`ifdef MEM_ARB_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, p_req, mem_ready, mem_rvalid;
  logic [15:0] i_addr, d_addr, p_addr;
  logic [63:0] mem_rdata;
  logic        i_gnt, d_gnt, p_gnt, mem_req;
  logic [15:0] mem_addr, r_addr;
  logic        i_rvalid, d_rvalid, p_rvalid, err;
  logic [63:0] r_data;

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .p_req(p_req), .p_addr(p_addr), .p_gnt(p_gnt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .p_rvalid(p_rvalid),
    .r_addr(r_addr), .r_data(r_data), .err(err)
  );

  // Reference model: in-flight reads as a plain queue, oldest first.
  typedef struct { bit [2:0] mask; bit [13:0] blk; } ent_t;
  typedef struct { bit [2:0] mask; bit [15:0] addr; bit [63:0] data; int due; } rsp_t;
  ent_t mq[$];
  rsp_t sb[$];
  int   starve  = 0;
  bit   exp_err = 1'b0;
  int   cyc     = 0;
  int   tests   = 0;
  int   fails   = 0;

  bit          last_gi, last_gd;
  logic        obs_i_gnt, obs_d_gnt, obs_p_gnt, obs_mem_req, obs_err;
  logic [15:0] obs_mem_addr, obs_r_addr;
  logic [2:0]  obs_rv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit ir, input logic [15:0] ia, input bit dr, input logic [15:0] da,
                       input bit pr, input logic [15:0] pa, input bit rdy, input bit rv,
                       input logic [63:0] rd);
    i_req = ir; i_addr = ia; d_req = dr; d_addr = da; p_req = pr; p_addr = pa;
    mem_ready = rdy; mem_rvalid = rv; mem_rdata = rd;
  endtask

  // One clock: inputs are already driven (posedge+1); check at negedge,
  // advance the model, return at the next posedge+1.
  task automatic run_cycle();
    bit pop, dslot, pslot, mrg, i_ok, d_ok, gi, gd, pdup, gpi, issue;
    int midx;
    bit [13:0] ib, db, pb, wb;
    ent_t ne;
    rsp_t r;
    @(negedge clk);
    obs_i_gnt = i_gnt; obs_d_gnt = d_gnt; obs_p_gnt = p_gnt; obs_mem_req = mem_req;
    obs_mem_addr = mem_addr; obs_r_addr = r_addr; obs_err = err;
    obs_rv = {p_rvalid, d_rvalid, i_rvalid};
    chk("err", err, exp_err);
    ib = i_addr[15:2]; db = d_addr[15:2]; pb = p_addr[15:2];
    pop   = mem_rvalid && (mq.size() > 0);
    dslot = (mq.size() < MAX_OUT) || pop;
    pslot = (mq.size() < MAX_OUT - 1);
    midx  = -1;
    if (MERGE && d_req)
      foreach (mq[k])
        if (midx < 0 && !(pop && k == 0) && mq[k].mask[2] && mq[k].blk == db) midx = k;
    mrg  = (midx >= 0);
    i_ok = i_req && mem_ready && dslot;
    d_ok = d_req && (mrg || (mem_ready && dslot));
    gi   = i_ok && (!d_ok || starve == STARVE_LIM);
    gd   = d_ok && !gi;
    wb   = gi ? ib : db;
    pdup = 1'b0;
    if (p_req) begin
      foreach (mq[k]) if (mq[k].blk == pb) pdup = 1'b1;
      if ((gi || gd) && wb == pb) pdup = 1'b1;
    end
    gpi   = p_req && !pdup && !gi && !gd && mem_ready && pslot;
    issue = gi || (gd && !mrg) || gpi;
    chk("i_gnt", i_gnt, gi);
    chk("d_gnt", d_gnt, gd);
    chk("p_gnt", p_gnt, pdup || gpi);
    chk("mem_req", mem_req, issue);
    if (issue) chk("mem_addr", mem_addr, {gpi ? pb : wb, 2'b00});
    if (gd && mrg) mq[midx].mask[1] = 1'b1;
    if (pop) begin
      r.mask = mq[0].mask; r.addr = {mq[0].blk, 2'b00}; r.data = mem_rdata; r.due = cyc + 1;
      sb.push_back(r);
      mq.delete(0);
    end else if (mem_rvalid) begin
      exp_err = 1'b1;
    end
    if (issue) begin
      ne.mask = gi ? 3'b001 : (gpi ? 3'b100 : 3'b010);
      ne.blk  = gpi ? pb : wb;
      mq.push_back(ne);
    end
    if (!i_req || gi) starve = 0;
    else if (gd && starve < STARVE_LIM) starve++;
    last_gi = gi; last_gd = gd;
    @(posedge clk); #1;
  endtask

  // Response monitor: every strobe must match the oldest expected response,
  // in the cycle it is due.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin : mon
        logic [2:0] got;
        rsp_t e;
        got = {p_rvalid, d_rvalid, i_rvalid};
        if (got != 3'b000) begin
          if (sb.size() == 0) chk("spurious_rvalid", got, 3'b000);
          else begin
            e = sb.pop_front();
            chk("rsp_cycle", cyc, e.due);
            chk("rsp_mask", got, e.mask);
            chk("rsp_addr", r_addr, e.addr);
            chk("rsp_data", r_data, e.data);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("rsp_missing", got, e.mask);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    mq.delete(); sb.delete(); starve = 0; exp_err = 1'b0;
    #1;
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_p_gnt", p_gnt, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_rvalid", {p_rvalid, d_rvalid, i_rvalid}, 3'b000);
    chk("rst_err", err, 1'b0);
    chk("rst_r_addr", r_addr, 16'h0000);
    chk("rst_r_data", r_data, 64'h0);
    @(posedge clk); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * MAX_OUT && mq.size() > 0; k++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 1, {$urandom, $urandom});
      run_cycle();
    end
    chk("drain_empty", mq.size(), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_cycle();
    run_cycle();
  endtask

  function automatic logic [15:0] rand_addr();
    return 16'h0040 + 16'($urandom_range(0, 39));
  endfunction

  initial begin
    bit ir, dr, pr, rdy, rv;
    logic [15:0] ia, da, pa;
    rst_n = 1'b1;
    drive(1, 16'h0100, 1, 16'h0200, 1, 16'h0300, 1, 0, 0);
    #2;
    do_reset();

    // Single i miss, memory latency 3.
    drive(1, 16'h1235, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    chk("t1_i_gnt", obs_i_gnt, 1'b1);
    chk("t1_mem_addr", obs_mem_addr, 16'h1234);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle(); run_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 1, 64'hA5A5_0000_1234_5A5A); run_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    chk("t1_i_rvalid", obs_rv, 3'b001);
    chk("t1_r_addr", obs_r_addr, 16'h1234);

    // Priority d > i > p.
    drive(1, 16'h0100, 1, 16'h0200, 1, 16'h0300, 1, 0, 0); run_cycle();
    chk("t2_d_first", obs_d_gnt, 1'b1);
    drive(1, 16'h0100, 0, 0, 1, 16'h0300, 1, 0, 0); run_cycle();
    chk("t2_i_second", obs_i_gnt, 1'b1);
    drive(0, 0, 0, 0, 1, 16'h0300, 1, 0, 0); run_cycle();
    chk("t2_p_third", obs_p_gnt & obs_mem_req, 1'b1);
    drain();

    // Starvation: d held continuously, i forced through on the 9th cycle.
    for (int k = 0; k < 9; k++) begin
      drive(1, 16'h0500, 1, 16'h0600 + 16'(k * 4), 0, 0, 1, mq.size() > 0, {$urandom, $urandom});
      run_cycle();
      if (k < 8) chk("t3_d_wins", obs_d_gnt, 1'b1);
      else chk("t3_i_forced", {obs_i_gnt, obs_d_gnt}, 2'b10);
    end
    drain();

    // Capacity: prefetch reserve and full FIFO.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 16'h1000 + 16'(k * 4), 0, 0, 1, 0, 0); run_cycle();
    end
    drive(0, 0, 0, 0, 1, 16'h2000, 1, 0, 0); run_cycle();
    chk("t4_p_withheld", obs_p_gnt, 1'b0);
    drive(0, 0, 1, 16'h100C, 1, 16'h2000, 1, 0, 0); run_cycle();
    chk("t4_d_at_c3", {obs_d_gnt, obs_p_gnt}, 2'b10);
    drive(1, 16'h3000, 1, 16'h3004, 1, 16'h2000, 1, 0, 0); run_cycle();
    chk("t4_full_none", {obs_i_gnt, obs_d_gnt, obs_p_gnt, obs_mem_req}, 4'b0000);
    drive(1, 16'h3000, 1, 16'h3004, 1, 16'h2000, 1, 1, 64'h1111); run_cycle();
    chk("t4_pop_grant", obs_d_gnt, 1'b1);
    drive(1, 16'h3000, 0, 0, 0, 0, 1, 1, 64'h2222); run_cycle();
    chk("t4_i_after", obs_i_gnt, 1'b1);
    drain();

    // Prefetch dedupe against an in-flight block.
    drive(1, 16'h0040, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    drive(0, 0, 0, 0, 1, 16'h0042, 1, 0, 0); run_cycle();
    chk("t5_dedupe", {obs_p_gnt, obs_mem_req}, 2'b10);
    drain();

    // Demand to a block in flight as a prefetch.
    drive(0, 0, 0, 0, 1, 16'h0080, 1, 0, 0); run_cycle();
    drive(0, 0, 1, 16'h0083, 0, 0, 1, 0, 0); run_cycle();
`ifdef MEM_ARB_MERGE_EN
    chk("t6_merge", {obs_d_gnt, obs_mem_req}, 2'b10);
`else
    chk("t6_no_merge", {obs_d_gnt, obs_mem_req, obs_mem_addr}, {2'b11, 16'h0080});
`endif
    drive(0, 0, 0, 0, 0, 0, 1, 1, 64'hBEEF); run_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    chk("t6_rsp_mask", obs_rv, MERGE ? 3'b110 : 3'b100);
    chk("t6_rsp_addr", obs_r_addr, 16'h0080);
    drain();

    // Response with nothing in flight: sticky error.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 64'h77); run_cycle();
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    chk("t7_err_set", obs_err, 1'b1);
    run_cycle(); run_cycle();
    chk("t7_err_sticky", obs_err, 1'b1);

    // Reset mid-burst with three reads in flight.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 16'h4000 + 16'(k * 4), 0, 0, 1, 0, 0); run_cycle();
    end
    drive(1, 16'h5000, 1, 16'h5004, 1, 16'h5008, 1, 1, 64'h99);
    do_reset();
    drive(1, 16'h0044, 0, 0, 0, 0, 1, 0, 0); run_cycle();
    chk("t8_after_rst", {obs_i_gnt, obs_mem_req}, 2'b11);
    drain();

    // Randomized traffic against the model.
    ir = 0; dr = 0; ia = 0; da = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir && $urandom_range(0, 3) == 0) begin ir = 1; ia = rand_addr(); end
      if (!dr && $urandom_range(0, 3) == 0) begin dr = 1; da = rand_addr(); end
      pr  = ($urandom_range(0, 2) == 0);
      pa  = rand_addr();
      rdy = ($urandom_range(0, 3) != 0);
      rv  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      drive(ir, ia, dr, da, pr, pa, rdy, rv, {$urandom, $urandom});
      run_cycle();
      if (last_gi) ir = 0;
      if (last_gd) dr = 0;
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one pipelined memory read port among three requesters: instruction-cache miss fill (i), data-cache demand miss (d) and data prefetcher (p).
- Grants at most one request per cycle and records each in-flight request in an in-order tracking FIFO.
- Routes each 64-bit block response back to the requester(s) that asked for it.
- Sits between the two-way caches/prefetcher and the memory model.

Parameters:
- MAX_OUT, 4, maximum in-flight memory requests (tracking FIFO depth, power of 2, >= 2).
- STARVE_LIM, 8, consecutive cycles i may be denied while d wins before i is forced to win.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  icache miss request, held with i_addr until i_gnt
- i_addr  in  16  icache word address
- i_gnt  out  1  i request accepted this cycle (combinational)
- d_req  in  1  dcache demand request, held until d_gnt
- d_addr  in  16  dcache word address
- d_gnt  out  1  d request accepted this cycle
- p_req  in  1  prefetch request, may be withdrawn at any time
- p_addr  in  16  prefetch word address
- p_gnt  out  1  p request accepted or dropped this cycle
- mem_req  out  1  issue read to memory
- mem_addr  out  16  block address, {addr[15:2],2'b00}
- mem_ready  in  1  memory can accept mem_req this cycle
- mem_rvalid  in  1  in-order response valid
- mem_rdata  in  64  response block
- i_rvalid, d_rvalid, p_rvalid  out  1 each  response strobe per requester (registered)
- r_addr  out  16  block address of the registered response
- r_data  out  64  registered response block
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0, async): tracking FIFO emptied, starvation counter cleared, err=0, all rvalid=0, r_addr=0, r_data=0.
  - All gnt and mem_req outputs evaluate to 0 while reset is asserted.
  - Memory is reset together with this block, so in-flight responses are discarded.
- Occupancy count C, 0..MAX_OUT.
- Slot available for demand (i/d): C<MAX_OUT, or mem_rvalid pops the FIFO this cycle.
- Slot available for prefetch: C<MAX_OUT-1, one slot always reserved for demand.
- Issue requires mem_ready=1 and an available slot. At most one gnt per cycle.
- Priority: d > i > p.
  - Starvation counter increments each cycle i_req=1 and d wins; it clears when i is granted or i_req=0.
  - When the counter equals STARVE_LIM, i beats d.
- On grant:
  - mem_req=1, mem_addr = block address of the winner.
  - FIFO push {src_mask one-hot(i=001,d=010,p=100), block address}.
  - Push and pop in the same cycle: C unchanged.
- Prefetch dedupe: p_req whose block address equals any valid FIFO entry, or the block granted to i/d this cycle, gets p_gnt=1 with no mem_req and no push.
  - Dedupe needs no slot and no mem_ready.
- Response path: on mem_rvalid, pop the head entry.
  - Next cycle, assert the rvalid bits selected by src_mask for exactly one cycle.
  - r_addr = head address; r_data = mem_rdata.
  - Latency is 1 cycle from mem_rvalid to x_rvalid.
- mem_rvalid with C=0: no pop, no strobes, err<=1. err clears only on reset.
- FIFO pointers wrap modulo MAX_OUT.
- No FSM is needed beyond the FIFO and counter; the datapath is fully pipelined.

Optional Feature:
- Macro MEM_ARB_MERGE_EN.
- Defined: a d_req whose block address matches a valid FIFO entry with the p bit set gets d_gnt=1 with no mem_req.
  - The d bit is ORed into that entry's src_mask.
  - The response then strobes p_rvalid and d_rvalid together.
  - A merge uses no slot and does not need mem_ready.
  - If the matching entry pops in the same cycle, no merge: d is issued normally.
- Undefined: d is always issued to memory as a new request.

Test Plan:
- Single i miss, i_addr=0x1235, memory latency 3 -> i_gnt and mem_req with mem_addr=0x1234 in the same cycle; i_rvalid=1 with r_addr=0x1234 exactly 4 cycles after grant.
- i, d and p all requesting, mem_ready=1, C=0 -> grant order d, i, p over successive cycles; with d held continuously, i is granted on the 9th cycle (STARVE_LIM=8).
- MAX_OUT=4, memory stalls responses -> p_gnt withheld at C=3 while d_req is still granted at C=3; all gnts are 0 at C=4; a mem_rvalid at C=4 allows a demand grant in the same cycle.
- p_addr=0x0042 while an entry for 0x0040 is in flight -> p_gnt=1, mem_req=0, C unchanged.
- MEM_ARB_MERGE_EN defined, p in flight for 0x0080, d_addr=0x0083 -> d_gnt=1, mem_req=0; on response p_rvalid=d_rvalid=1 and r_addr=0x0080. Same stimulus with the macro undefined -> a second mem_req is issued.
- mem_rvalid with C=0 -> err=1 sticky; rst_n low mid-burst with C=3 -> C=0, all outputs 0 immediately, err=0.
